turbo_deinterleaver: RTL and testbench

- Receive-side counterpart of the HPGP turbo interleaver. Takes a block of interleaved 2-bit symbol pairs and restores natural order.
- Each received pair is written into a single-port-per-side buffer at its permuted address, with the pair-bit swap undone. The buffer is then read out linearly.
- Sits between the turbo decoder's input LLR/hard-bit path and the PB reassembly logic.
- Round trip interleaver -> turbo_deinterleaver returns the original pair stream.

---
 rtl/turbo_deinterleaver_if.sv | 38 +++
 rtl/turbo_deinterleaver.sv | 207 ++++++++++++++++++++
 tb/tb_turbo_deinterleaver.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/turbo_deinterleaver_if.sv
// -----------------------------------------------------------------------------
// turbo_deinterleaver_if
// Stream bundle between the turbo_deinterleaver and its neighbours.
//   din       [1:0]  interleaved symbol pair (producer -> deinterleaver)
//   din_vld          din valid
//   din_rdy          deinterleaver can take a pair (transfer on vld & rdy)
//   dout      [1:0]  natural-order pair (deinterleaver -> consumer)
//   dout_vld         dout valid, no backpressure
//   dout_last        final pair of a block
// master = stream source/sink side (decoder input path / PB reassembly)
// slave  = the deinterleaver itself
// -----------------------------------------------------------------------------
interface turbo_deinterleaver_if;
    logic [1:0] din;
    logic       din_vld;
    logic       din_rdy;
    logic [1:0] dout;
    logic       dout_vld;
    logic       dout_last;

    modport master (
        output din,
        output din_vld,
        input  din_rdy,
        input  dout,
        input  dout_vld,
        input  dout_last
    );

    modport slave (
        input  din,
        input  din_vld,
        output din_rdy,
        output dout,
        output dout_vld,
        output dout_last
    );
endinterface

// File: rtl/turbo_deinterleaver.sv
// -----------------------------------------------------------------------------
// turbo_deinterleaver
// Receive-side inverse of the HPGP turbo interleaver. Received pair j is
// written to buffer address pi(j) = (P_STEP*j + P_OFF) mod N with the pair
// bits swapped back for odd j; the buffer is then read out linearly.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   pb_size   block size code: 0=64, 1=544, 2=2080, 3=reserved (treated as 64)
//   size_err  one-cycle pulse after a reserved pb_size was sampled
//   busy      high while filling or draining a block
//   io        stream bundle (slave modport): din/din_vld/din_rdy in,
//             dout/dout_vld/dout_last out
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for pair 0 of a block; N is latched on its acceptance
// FILL  | writing pairs 1..N-1 at their permuted addresses
// DRAIN | issuing linear reads 0..N-1, input stalled
// -----------------------------------------------------------------------------
module turbo_deinterleaver #(
    parameter int MAX_N  = 2080,
    parameter int AW     = 12,
    parameter int P_STEP = 19,
    parameter int P_OFF  = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            pb_size,
    output logic                  size_err,
    output logic                  busy,
    turbo_deinterleaver_if.slave  io
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;

    logic [AW-1:0]   n_q;        // block length latched on pair 0
    logic [AW-1:0]   n_dec;      // block length decoded from pb_size
    logic [AW-1:0]   n_cur;      // length in force for the address step
    logic [AW-1:0]   j_q;        // received pair index
    logic [AW-1:0]   i_q;        // read index
    logic [AW-1:0]   addr_q;     // pi(j_q), kept incrementally
    logic [AW-1:0]   addr_nxt;
    logic [AW:0]     addr_sum;

    logic            accept;
    logic            last_in;
    logic            last_rd;
    logic            wr_en;
    logic            rd_en;
    logic [1:0]      wr_data;

    logic [1:0]      mem [MAX_N];
    logic [1:0]      rd_data_q;
    logic            rd_vld_q;
    logic            rd_last_q;

    // ---------------------------------------------------------------- decode
    always_comb begin
        n_dec = AW'(64);
        unique case (pb_size)
            2'd1:    n_dec = AW'(544);
            2'd2:    n_dec = AW'(2080);
            default: n_dec = AW'(64);   // 0 and reserved 3
        endcase
    end

    // Pair 0 is written in IDLE before n_q is loaded, so its successor
    // address must be reduced modulo the freshly decoded length.
    assign n_cur   = (state_q == ST_IDLE) ? n_dec : n_q;

    assign accept  = io.din_vld & io.din_rdy;
    assign last_in = (state_q == ST_FILL) && (j_q == n_q - AW'(1));
    assign last_rd = (i_q == n_q - AW'(1));

    // a(j+1) = a(j) + P_STEP, minus N once if it wrapped. a(j) < N and
    // P_STEP < N, so a single conditional subtract is enough.
    assign addr_sum = {1'b0, addr_q} + (AW+1)'(P_STEP);
    assign addr_nxt = (addr_sum >= {1'b0, n_cur}) ? AW'(addr_sum - {1'b0, n_cur})
                                                  : AW'(addr_sum);

    // Odd pairs were bit-swapped by the interleaver.
    assign wr_data  = j_q[0] ? {io.din[0], io.din[1]} : io.din;

    // ------------------------------------------------------- state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------ next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (accept && last_in) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (last_rd) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------- state outputs
    always_comb begin
        io.din_rdy = 1'b1;
        busy       = 1'b0;
        rd_en      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                io.din_rdy = 1'b1;
            end
            ST_FILL: begin
                io.din_rdy = 1'b1;
                busy       = 1'b1;
            end
            ST_DRAIN: begin
                io.din_rdy = 1'b0;
                busy       = 1'b1;
                rd_en      = 1'b1;
            end
            default: begin
                io.din_rdy = 1'b1;
            end
        endcase
    end

    assign wr_en = accept;

    // -------------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_q       <= AW'(64);
            j_q       <= '0;
            i_q       <= '0;
            addr_q    <= AW'(P_OFF);
            size_err  <= 1'b0;
            rd_vld_q  <= 1'b0;
            rd_last_q <= 1'b0;
        end else begin
            size_err <= accept && (state_q == ST_IDLE) && (pb_size == 2'd3);

            if (accept && (state_q == ST_IDLE)) begin
                n_q <= n_dec;
            end

            // j/addr park at 0/P_OFF between blocks, so pair 0 in IDLE
            // uses the same write path as every other pair.
            if (accept) begin
                if (last_in) begin
                    j_q    <= '0;
                    addr_q <= AW'(P_OFF);
                end else begin
                    j_q    <= j_q + AW'(1);
                    addr_q <= addr_nxt;
                end
            end

            if (rd_en) begin
                i_q <= last_rd ? '0 : i_q + AW'(1);
            end

            rd_vld_q  <= rd_en;
            rd_last_q <= rd_en && last_rd;
        end
    end

    // Buffer: one write port (fill side), one read port (drain side). The
    // first write of the next block may coincide with the cycle after the
    // final read issue; that read data is already in rd_data_q by then.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr_q] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[i_q];
        end
    end

    // rd_data_q is not reset; gating with the valid keeps dout at 0 out of
    // reset and between blocks.
    assign io.dout      = rd_vld_q ? rd_data_q : 2'b00;
    assign io.dout_vld  = rd_vld_q;
    assign io.dout_last = rd_last_q;

endmodule

// File: tb/tb_turbo_deinterleaver.sv
module tb_turbo_deinterleaver;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] pb_size;
    logic       size_err;
    logic       busy;

    turbo_deinterleaver_if bus ();

    turbo_deinterleaver dut (
        .clk      (clk),
        .rst      (rst),
        .pb_size  (pb_size),
        .size_err (size_err),
        .busy     (busy),
        .io       (bus.slave)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         failures = 0;
    logic [1:0] x [2080];
    logic [1:0] y [2080];
    logic [1:0] got [2080];
    logic [1:0] exp_q [$];
    logic       exp_last_q [$];
    int         out_idx = 0;
    int         last_idx = -1;
    int         cyc = 0;
    int         last_acc_cyc = 0;
    int         size_err_cnt = 0;
    int         rdy_low_run = 0;
    int         last_low_run = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int pi(input int j, input int n);
        return (19 * j + 7) % n;
    endfunction

    function automatic int size_of(input int code);
        return (code == 1) ? 544 : (code == 2) ? 2080 : 64;
    endfunction

    function automatic logic [1:0] swp(input logic [1:0] v);
        return {v[0], v[1]};
    endfunction

    // Reference interleaver: y[j] = x[pi(j)], bit-swapped for odd j.
    task automatic prep_random(input int n);
        for (int k = 0; k < n; k++) x[k] = 2'($urandom);
        for (int j = 0; j < n; j++) y[j] = j[0] ? swp(x[pi(j, n)]) : x[pi(j, n)];
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(x[k]);
            exp_last_q.push_back(k == n - 1);
        end
    endtask

    // Expected natural order derived from a given interleaved block.
    task automatic prep_from_y(input int n);
        for (int j = 0; j < n; j++) x[pi(j, n)] = j[0] ? swp(y[j]) : y[j];
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(x[k]);
            exp_last_q.push_back(k == n - 1);
        end
    endtask

    // Drives pairs 0..npairs-1; the last pair is left on the bus and
    // transfers at the next rising edge.
    task automatic send_block(input int code, input int gap_pct, input bit toggle,
                              input int npairs);
        pb_size = 2'(code);
        for (int j = 0; j < npairs; j++) begin
            bit done = 1'b0;
            int guard = 0;
            while (!done) begin
                @(posedge clk);
                #1;
                if (toggle && j > 0) pb_size = 2'($urandom_range(0, 3));
                bus.din     = y[j];
                bus.din_vld = ($urandom_range(0, 99) >= gap_pct);
                if (bus.din_vld && bus.din_rdy) done = 1'b1;
                guard++;
                if (guard > 5000) begin
                    check("send_timeout", guard, 0);
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic idle_bus();
        @(posedge clk);
        #1;
        bus.din_vld = 1'b0;
    endtask

    task automatic wait_drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 10000) begin
            @(negedge clk);
            g++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    // Compare process: every output pair against the model queue.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (bus.dout_vld) begin
                if (out_idx == 0) check("first_out_latency", cyc - last_acc_cyc, 2);
                if (exp_q.size() == 0) begin
                    check("extra_dout_vld", 1, 0);
                end else begin
                    logic [1:0] e;
                    logic       el;
                    e  = exp_q.pop_front();
                    el = exp_last_q.pop_front();
                    check("dout", int'(bus.dout), int'(e));
                    check("dout_last", int'(bus.dout_last), int'(el));
                end
                if (out_idx < 2080) got[out_idx] = bus.dout;
                if (bus.dout_last) begin
                    last_idx = out_idx;
                    out_idx  = 0;
                end else begin
                    out_idx++;
                end
            end
            if (bus.din_vld && bus.din_rdy) last_acc_cyc = cyc;
            if (size_err) size_err_cnt++;
            if (!bus.din_rdy) begin
                rdy_low_run++;
            end else begin
                if (rdy_low_run > 0) last_low_run = rdy_low_run;
                rdy_low_run = 0;
            end
        end
    end

    initial begin
        int cnt;
        int g;
        rst         = 1'b1;
        pb_size     = 2'd0;
        bus.din     = 2'b00;
        bus.din_vld = 1'b0;
        #1;
        check("rst_dout", int'(bus.dout), 0);
        check("rst_dout_vld", int'(bus.dout_vld), 0);
        check("rst_dout_last", int'(bus.dout_last), 0);
        check("rst_size_err", int'(size_err), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_din_rdy", int'(bus.din_rdy), 1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // PB16 basic with literal expectations
        for (int j = 0; j < 64; j++) y[j] = 2'b00;
        y[0] = 2'b01; y[1] = 2'b01; y[2] = 2'b10; y[3] = 2'b11;
        prep_from_y(64);
        size_err_cnt = 0;
        send_block(0, 0, 1'b0, 64);
        idle_bus();
        wait_drain();
        check("pb16_idx7", int'(got[7]), 1);
        check("pb16_idx26", int'(got[26]), 2);
        check("pb16_idx45", int'(got[45]), 2);
        check("pb16_idx0", int'(got[0]), 3);
        cnt = 0;
        for (int k = 1; k < 64; k++)
            if (k != 7 && k != 26 && k != 45 && got[k] != 2'b00) cnt++;
        check("pb16_others_zero", cnt, 0);
        check("pb16_last_idx", last_idx, 63);

        // Round trip for every size, gapless
        for (int code = 0; code < 3; code++) begin
            prep_random(size_of(code));
            send_block(code, 0, 1'b0, size_of(code));
            idle_bus();
            wait_drain();
            check("roundtrip_last_idx", last_idx, size_of(code) - 1);
        end

        // PB136 with gaps and pb_size wandering mid-block
        prep_random(544);
        send_block(1, 30, 1'b1, 544);
        idle_bus();
        pb_size = 2'd0;
        wait_drain();
        check("gapped_last_idx", last_idx, 543);
        check("no_size_err_so_far", size_err_cnt, 0);

        // Back-to-back PB16 with din_vld held high throughout
        prep_random(64);
        send_block(0, 0, 1'b0, 64);
        prep_random(64);
        send_block(0, 0, 1'b0, 64);
        check("b2b_rdy_low_cycles", last_low_run, 64);
        idle_bus();
        wait_drain();
        check("b2b_rdy_low_cycles_2", last_low_run, 64);
        check("b2b_last_idx", last_idx, 63);

        // Reserved size code
        size_err_cnt = 0;
        prep_random(64);
        send_block(3, 0, 1'b0, 64);
        idle_bus();
        pb_size = 2'd0;
        wait_drain();
        check("reserved_size_err_pulses", size_err_cnt, 1);
        check("reserved_last_idx", last_idx, 63);

        // Reset during FILL at j = 20
        prep_random(64);
        send_block(0, 0, 1'b0, 20);
        idle_bus();
        check("fill_busy_before_rst", int'(busy), 1);
        #2 rst = 1'b1;
        #1;
        check("fillrst_busy", int'(busy), 0);
        check("fillrst_din_rdy", int'(bus.din_rdy), 1);
        check("fillrst_dout_vld", int'(bus.dout_vld), 0);
        exp_q.delete();
        exp_last_q.delete();
        out_idx = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 check("fillrst_rdy_after", int'(bus.din_rdy), 1);

        // Reset during DRAIN around i = 30
        prep_random(64);
        send_block(0, 0, 1'b0, 64);
        idle_bus();
        g = 0;
        while (exp_q.size() > 34 && g < 2000) begin
            @(negedge clk);
            g++;
        end
        check("drain_reached", int'(exp_q.size() <= 34), 1);
        check("drain_dout_vld_before_rst", int'(bus.dout_vld), 1);
        #2 rst = 1'b1;
        #1;
        check("drainrst_dout", int'(bus.dout), 0);
        check("drainrst_dout_vld", int'(bus.dout_vld), 0);
        check("drainrst_dout_last", int'(bus.dout_last), 0);
        check("drainrst_busy", int'(busy), 0);
        check("drainrst_din_rdy", int'(bus.din_rdy), 1);
        exp_q.delete();
        exp_last_q.delete();
        out_idx = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 check("drainrst_rdy_after", int'(bus.din_rdy), 1);

        // Fresh blocks after reset
        prep_random(64);
        send_block(0, 0, 1'b0, 64);
        idle_bus();
        wait_drain();
        check("post_rst_last_idx", last_idx, 63);
        prep_random(544);
        send_block(1, 10, 1'b0, 544);
        idle_bus();
        wait_drain();
        check("post_rst_pb136_last_idx", last_idx, 543);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
